// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : fetch PC generator feeding a {pc, instr} FIFO, flushed on redirect
// Revision    : 1.0
// ============================================================================
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fetch_en,
  output logic [31:0]             imem_addr,
  input  logic [31:0]             imem_rdata,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_instr,
  output logic [31:0]             out_pc,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic w_pop;
  logic w_push;

  assign out_valid = (count_q != '0);
  assign w_pop     = out_valid && out_ready;
  // A full queue still accepts a fetch when the head leaves on the same edge.
  assign w_push    = fetch_en && !redirect_valid && ((count_q != C_FULL) || w_pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (w_push) begin
        wr_ptr_d   = wr_ptr_q + AW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (w_push && !w_pop) begin
        count_d = count_q + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        count_d = count_q - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: empty entries are masked on the outputs.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign count     = count_q;
  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : 32'h0;
  assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'h0;

endmodule
`default_nettype wire
